atm_pager_multi: RTL
====================

Name: atm_pager_multi

Overview:
- Next-generation ATM-style memory pager. One instance pages all NUM_WIN 16 KB windows of the Z80 address space.
- Each window has two maps, selected by pent1m_ROM. Page numbers are PAGE_W bits wide (8 bits gives 4 MB, 10 bits gives 16 MB).
- Adds synchronous reset, a shadow-register snapshot/restore for NMI service, and a parametrised DOS-entry Z80 clock stall.
- Sits between the Z80 bus decode and the DRAM/ROM address mux.

Parameters:
- NUM_WIN, 4, number of 16 KB windows paged; only 4 is legal, because za[15:14] selects the window.
- PAGE_W, 8, page number width; legal range 8..10. Bits above 7 come from the x3F7 extension port.
- STALL_CLKS, 3, fclk cycles the Z80 clock is held after dos_turn_on, in addition to the strobe cycle; legal range 1..7.
- DOS_HI, 6'h3D, value of za[13:8] that triggers DOS entry.

Ports:
- fclk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on posedge fclk.
- zpos, zneg  in  1 each  Z80 clock edge strobes, each one fclk wide.
- za  in  16  Z80 address.
- zd  in  8  Z80 write data.
- mreq_n, m1_n  in  1 each  Z80 control signals.
- pager_off  in  1  forces service ROM into every window.
- pent1m_ROM  in  1  map select (7FFD bit 4).
- pent1m_page  in  6  7FFD RAM page.
- pent1m_1m_on  in  1  enables 1 MB 7FFD addressing.
- pent1m_ram0_0  in  1  forces RAM page 0 into window 0.
- in_nmi, in_trdemu  in  1 each  force the service page into window 0.
- trdemu_wr_disable  in  1  write protect applied while window 0 is forced.
- atmF7_wr  in  1  one-cycle write strobe for the xxF7 ports.
- dos  in  1  current DOS state.
- snap_save, snap_restore  in  1 each  one-cycle shadow strobes.
- rd_win  in  2  readback window select.
- dos_turn_on, dos_turn_off  out  1 each  one-cycle strobes.
- zclk_stall  out  1  holds the Z80 clock.
- page  out  PAGE_W  page for the window selected by za[15:14].
- romnram  out  1  1 = ROM, 0 = RAM.
- wrdisable  out  1  write protect for the current access.
- rd_page0, rd_page1  out  PAGE_W each  raw page, map 0 / map 1, of window rd_win.
- rd_flags  out  6  {wrdis[1:0], dos7ffd[1:0], ramnrom[1:0]} of window rd_win.

Behaviour:
Storage
- Each window w and map m holds: pages[w][m] (PAGE_W bits), ext_hi[w][m] (2 bits), ramnrom, dos7ffd, wrdis.
- Every storage bit has a shadow copy.

Reset (rst_n=0 at a fclk edge)
- pages all ones; ext_hi = 2'b11.
- ramnrom = 0.
- dos7ffd = 1 for window 0, 0 for windows 1..3.
- wrdis = 0.
- page = all ones, romnram = 1, wrdisable = 0.
- Stall FSM goes to IDLE; the m1/mreq sample registers are set to 1.
- Reset asserted during a stall clears zclk_stall on the next cycle. Shadow registers are not reset.

Port writes
- A write requires atmF7_wr=1. The target window is w = za[15:14]; the target map is pent1m_ROM.
- {za[11],za[10]} selects the port:
  - 11, xFF7: page = ~{ext_hi, 2'b11, zd[5:0]} truncated to PAGE_W; ramnrom = zd[6]; dos7ffd = zd[7].
  - 01, x7F7: page = ~{ext_hi, zd} truncated to PAGE_W; ramnrom = 1; dos7ffd unchanged.
  - 10, xBF7: wrdis = zd[0].
  - 00, x3F7: ext_hi = zd[1:0]. Stored even when PAGE_W = 8, but unused.
- Written values are visible on outputs two fclk cycles after the strobe (storage register, then output register).

Output mux (registered, 1-cycle latency from za)
- The sections below apply in priority order; the first that matches wins.
- pager_off=1: page all ones, romnram = 1, wrdisable = 0.
- w = 0 and (in_nmi or in_trdemu):
  - romnram = 0; wrdisable = trdemu_wr_disable.
  - page = all ones with bit 0 = in_nmi (in_nmi gives ...FF, otherwise ...FE).
- w = 0 and pent1m_ram0_0: page 0, romnram = 0, wrdisable = trdemu_wr_disable.
- Otherwise, with map m = pent1m_ROM: romnram = ~ramnrom; wrdisable = wrdis; page is chosen by:
  - dos7ffd = 0: page = pages[w][m].
  - dos7ffd = 1, RAM, pent1m_1m_on = 1: replace the low 6 bits of pages[w][m] with pent1m_page.
  - dos7ffd = 1, RAM, pent1m_1m_on = 0: replace the low 3 bits of pages[w][m] with pent1m_page[2:0].
  - dos7ffd = 1, ROM: replace bit 0 of pages[w][m] with dos.

DOS strobes
- m1_n is sampled on zpos; mreq_n is sampled on zneg.
- Let fetch = zneg & ~m1_q & ~mreq_n & mreq_q.
- dos_turn_on = fetch & w==0 & za[13:8]==DOS_HI & dos7ffd[0][1] & ~ramnrom[0][1] & pent1m_ROM.
- dos_turn_off = fetch & ramnrom[w][pent1m_ROM].
- Both strobes are combinational.

Stall FSM
- States IDLE and STALL, with a counter cnt of 3 bits.
- In IDLE, dos_turn_on moves to STALL with cnt = STALL_CLKS.
- In STALL, cnt decrements each cycle; at cnt = 1 the FSM returns to IDLE.
- dos_turn_on while in STALL reloads cnt to STALL_CLKS.
- zclk_stall = dos_turn_on | (state == STALL). For STALL_CLKS = 3 it is high for exactly 4 consecutive cycles.

Shadow registers
- snap_save copies all live storage to the shadow in one cycle.
- snap_restore copies the shadow back to live storage in one cycle.
- snap_restore together with a port write in the same cycle: the port write wins for its target field; all other fields restore.
- snap_save and snap_restore in the same cycle: the two sets swap.
- Port writes in the same cycle as snap_save are not captured in the shadow.

Readback
- rd_page0, rd_page1 and rd_flags are combinational from live storage for window rd_win.

Test Plan:
- Reset, then za=16'h0000, 16'h4000, 16'hC000 -> page=8'hFF, romnram=1, wrdisable=0; rd_flags for rd_win=0 = 6'b001100.
- pent1m_ROM=0, atmF7_wr with za=16'hC7F7, zd=8'h05 -> two cycles later, za=16'hC000 gives page=8'hFA, romnram=0; windows 0..2 unchanged.
- PAGE_W=10: x3F7 write with zd=2'b01, then x7F7 write with zd=8'h00, both to window 1 -> page=10'h2FF.
- Window 0, map 1 holds ROM with dos7ffd=1, pent1m_ROM=1; M1 fetch at 16'h3D2F -> dos_turn_on for one cycle, zclk_stall high for STALL_CLKS+1 cycles. A second strobe during the stall extends it. rst_n=0 mid-stall drops zclk_stall next cycle.
- snap_save; x7F7 write to window 3 with zd=8'h10; snap_restore -> window 3 page returns to its pre-write value. Repeat with snap_restore coincident with the write -> the written value is retained.
- in_nmi=1 with pent1m_ram0_0=1 -> window 0 page=8'hFF, romnram=0; with in_trdemu only -> page=8'hFE, wrdisable=trdemu_wr_disable; pager_off=1 overrides both.

Source files
------------

// File: rtl/atm_pager_multi.sv
// atm_pager_multi: ATM-style four-window memory pager with shadow snapshot and DOS-entry Z80 clock stall
module atm_pager_multi #(
  parameter int         NUM_WIN    = 4,
  parameter int         PAGE_W     = 8,
  parameter int         STALL_CLKS = 3,
  parameter logic [5:0] DOS_HI     = 6'h3D
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              zpos,
  input  logic              zneg,
  input  logic [15:0]       za,
  input  logic [7:0]        zd,
  input  logic              mreq_n,
  input  logic              m1_n,
  input  logic              pager_off,
  input  logic              pent1m_ROM,
  input  logic [5:0]        pent1m_page,
  input  logic              pent1m_1m_on,
  input  logic              pent1m_ram0_0,
  input  logic              in_nmi,
  input  logic              in_trdemu,
  input  logic              trdemu_wr_disable,
  input  logic              atmF7_wr,
  input  logic              dos,
  input  logic              snap_save,
  input  logic              snap_restore,
  input  logic [1:0]        rd_win,
  output logic              dos_turn_on,
  output logic              dos_turn_off,
  output logic              zclk_stall,
  output logic [PAGE_W-1:0] page,
  output logic              romnram,
  output logic              wrdisable,
  output logic [PAGE_W-1:0] rd_page0,
  output logic [PAGE_W-1:0] rd_page1,
  output logic [5:0]        rd_flags
);
  typedef enum logic {IDLE, STALL} state_t;
  logic [PAGE_W-1:0] pages [NUM_WIN][2];
  logic [1:0]        ext_hi [NUM_WIN][2];
  logic              ramnrom [NUM_WIN][2];
  logic              dos7ffd [NUM_WIN][2];
  logic              wrdis [NUM_WIN][2];
  logic [PAGE_W-1:0] sh_pages [NUM_WIN][2];
  logic [1:0]        sh_ext_hi [NUM_WIN][2];
  logic              sh_ramnrom [NUM_WIN][2];
  logic              sh_dos7ffd [NUM_WIN][2];
  logic              sh_wrdis [NUM_WIN][2];
  logic [1:0]        w, port;
  logic              m;
  logic [9:0]        p_ff7, p_7f7;
  logic [PAGE_W-1:0] pg, pg_norm, page_d;
  logic              w0_svc, w0_ram0, rom_d, wrd_d;
  logic              m1_q, mreq_q, fetch;
  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic              unused_bits;
  assign w = za[15:14];
  assign m = pent1m_ROM;
  assign port = {za[11], za[10]};
  assign p_ff7 = ~{ext_hi[w][m], 2'b11, zd[5:0]};
  assign p_7f7 = ~{ext_hi[w][m], zd};
  assign unused_bits = ^{za[9:0], p_ff7, p_7f7};
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WIN; i++)
        for (int j = 0; j < 2; j++) begin
          pages[i][j]   <= '1;
          ext_hi[i][j]  <= 2'b11;
          ramnrom[i][j] <= 1'b0;
          dos7ffd[i][j] <= (i == 0);
          wrdis[i][j]   <= 1'b0;
        end
    end else begin
      if (snap_restore) begin
        pages   <= sh_pages;
        ext_hi  <= sh_ext_hi;
        ramnrom <= sh_ramnrom;
        dos7ffd <= sh_dos7ffd;
        wrdis   <= sh_wrdis;
      end
      // later assignments override the restore for the written fields only
      if (atmF7_wr) begin
        if (port == 2'b11) begin
          pages[w][m]   <= p_ff7[PAGE_W-1:0];
          ramnrom[w][m] <= zd[6];
          dos7ffd[w][m] <= zd[7];
        end
        if (port == 2'b01) begin
          pages[w][m]   <= p_7f7[PAGE_W-1:0];
          ramnrom[w][m] <= 1'b1;
        end
        if (port == 2'b10) wrdis[w][m] <= zd[0];
        if (port == 2'b00) ext_hi[w][m] <= zd[1:0];
      end
    end
  end
  always_ff @(posedge fclk) begin
    if (snap_save) begin
      sh_pages   <= pages;
      sh_ext_hi  <= ext_hi;
      sh_ramnrom <= ramnrom;
      sh_dos7ffd <= dos7ffd;
      sh_wrdis   <= wrdis;
    end
  end
  assign pg = pages[w][m];
  assign w0_svc = (w == 2'd0) & (in_nmi | in_trdemu);
  assign w0_ram0 = (w == 2'd0) & pent1m_ram0_0;
  assign pg_norm = !dos7ffd[w][m] ? pg :
                   !ramnrom[w][m] ? {pg[PAGE_W-1:1], dos} :
                   pent1m_1m_on   ? {pg[PAGE_W-1:6], pent1m_page} :
                                    {pg[PAGE_W-1:3], pent1m_page[2:0]};
  assign page_d = pager_off ? '1 : w0_svc ? {{(PAGE_W-1){1'b1}}, in_nmi} : w0_ram0 ? '0 : pg_norm;
  assign rom_d = pager_off | (!w0_svc & !w0_ram0 & !ramnrom[w][m]);
  assign wrd_d = pager_off ? 1'b0 : (w0_svc | w0_ram0) ? trdemu_wr_disable : wrdis[w][m];
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      page      <= '1;
      romnram   <= 1'b1;
      wrdisable <= 1'b0;
    end else begin
      page      <= page_d;
      romnram   <= rom_d;
      wrdisable <= wrd_d;
    end
  end
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      m1_q   <= 1'b1;
      mreq_q <= 1'b1;
    end else begin
      if (zpos) m1_q <= m1_n;
      if (zneg) mreq_q <= mreq_n;
    end
  end
  assign fetch = zneg & ~m1_q & ~mreq_n & mreq_q;
  assign dos_turn_on = fetch & (w == 2'd0) & (za[13:8] == DOS_HI) & dos7ffd[0][1] & ~ramnrom[0][1] & pent1m_ROM;
  assign dos_turn_off = fetch & ramnrom[w][m];
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (dos_turn_on) begin
      state_n = STALL;
      cnt_n = 3'(STALL_CLKS);
    end else if (state == STALL) begin
      cnt_n = cnt - 3'd1;
      state_n = (cnt == 3'd1) ? IDLE : STALL;
    end
  end
  assign zclk_stall = dos_turn_on | (state == STALL);
  assign rd_page0 = pages[rd_win][0];
  assign rd_page1 = pages[rd_win][1];
  assign rd_flags = {wrdis[rd_win][1], wrdis[rd_win][0], dos7ffd[rd_win][1], dos7ffd[rd_win][0],
                     ramnrom[rd_win][1], ramnrom[rd_win][0]};
endmodule
